// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - two-way intersection light sequencer paced by a 1 Hz seconds input
// Optional pedestrian walk phase is built when TRAFFIC_PED_EN is defined.
module traffic_light_fsm #(
    parameter int GREEN_S  = 10,
    parameter int YELLOW_S = 3,
    parameter int ALLRED_S = 1,
    parameter int CNT_W    = 8
`ifdef TRAFFIC_PED_EN
    ,
    parameter int WALK_S   = 5
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sec_clk,
`ifdef TRAFFIC_PED_EN
    input  logic             ped_req,
    output logic             walk,
`endif
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic [CNT_W-1:0] sec_left
);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_S - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_S - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_S - 1);
`ifdef TRAFFIC_PED_EN
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_S - 1);
`endif

    typedef enum logic [2:0] {
        ALLRED_A  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_B  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5
`ifdef TRAFFIC_PED_EN
        ,
        WALK      = 3'd6
`endif
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sec_q;
    logic             tick;
    logic             expire;
`ifdef TRAFFIC_PED_EN
    logic             pending_q;
    logic             pending_d;
`endif

    function automatic logic [CNT_W-1:0] load_of(input state_t s);
        logic [CNT_W-1:0] ld;
        case (s)
            NS_GREEN, EW_GREEN:   ld = GREEN_LD;
            NS_YELLOW, EW_YELLOW: ld = YELLOW_LD;
`ifdef TRAFFIC_PED_EN
            WALK:                 ld = WALK_LD;
`endif
            default:              ld = ALLRED_LD;
        endcase
        return ld;
    endfunction

    // Rising edge of the seconds square wave only; a falling edge is ignored.
    assign tick   = sec_clk & ~sec_q;
    assign expire = tick && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ALLRED_A;
            cnt_q     <= ALLRED_LD;
            sec_q     <= 1'b0;
`ifdef TRAFFIC_PED_EN
            pending_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sec_q     <= sec_clk;
`ifdef TRAFFIC_PED_EN
            pending_q <= pending_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ALLRED_A:  if (expire) state_d = NS_GREEN;
            NS_GREEN:  if (expire) state_d = NS_YELLOW;
            NS_YELLOW: if (expire) state_d = ALLRED_B;
            ALLRED_B:  if (expire) state_d = EW_GREEN;
            EW_GREEN:  if (expire) state_d = EW_YELLOW;
`ifdef TRAFFIC_PED_EN
            EW_YELLOW: if (expire) state_d = pending_q ? WALK : ALLRED_A;
            WALK:      if (expire) state_d = ALLRED_A;
`else
            EW_YELLOW: if (expire) state_d = ALLRED_A;
`endif
            default:   state_d = ALLRED_A;
        endcase

        // Every state change (including recovery from a corrupt encoding) reloads the phase length.
        if (state_d != state_q) begin
            cnt_d = load_of(state_d);
        end else if (tick) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

`ifdef TRAFFIC_PED_EN
    // Entering WALK serves the request, so the clear wins over a same-cycle press.
    always_comb begin
        pending_d = pending_q | (ped_req && (state_q != WALK));
        if ((state_d == WALK) && (state_q != WALK)) begin
            pending_d = 1'b0;
        end
    end

    assign walk = (state_q == WALK);
`endif

    always_comb begin
        ns_light = LAMP_R;
        ew_light = LAMP_R;
        case (state_q)
            NS_GREEN:  ns_light = LAMP_G;
            NS_YELLOW: ns_light = LAMP_Y;
            EW_GREEN:  ew_light = LAMP_G;
            EW_YELLOW: ew_light = LAMP_Y;
            default: begin
                ns_light = LAMP_R;
                ew_light = LAMP_R;
            end
        endcase
    end

    assign sec_left = cnt_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb/tb_traffic_light_fsm.sv - randomized self-checking bench for traffic_light_fsm
module tb_traffic_light_fsm;

    localparam int GREEN_S  = 4;
    localparam int YELLOW_S = 2;
    localparam int ALLRED_S = 1;
    localparam int WALK_S   = 3;
    localparam int CNT_W    = 8;
    localparam int LOOP     = 2 * ALLRED_S + 2 * GREEN_S + 2 * YELLOW_S;
    localparam int VW       = 7 + CNT_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sec_clk = 1'b0;
    logic             ped_req = 1'b0;
    logic             walk;
    logic [2:0]       ns_light;
    logic [2:0]       ew_light;
    logic [CNT_W-1:0] sec_left;

    int n_pass  = 0;
    int n_total = 0;

    // Model: position in ticks since the start of the current loop.
    int m_pos  = 0;
    bit m_prev = 1'b0;
    bit m_pend = 1'b0;
    bit m_tick = 1'b0;

    logic sq   = 1'b0;
    int   sq_n = 0;
    int   sq_h = 5;

`ifdef TRAFFIC_PED_EN
    traffic_light_fsm #(
        .GREEN_S (GREEN_S),
        .YELLOW_S(YELLOW_S),
        .ALLRED_S(ALLRED_S),
        .CNT_W   (CNT_W),
        .WALK_S  (WALK_S)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sec_clk (sec_clk),
        .ped_req (ped_req),
        .walk    (walk),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .sec_left(sec_left)
    );
`else
    traffic_light_fsm #(
        .GREEN_S (GREEN_S),
        .YELLOW_S(YELLOW_S),
        .ALLRED_S(ALLRED_S),
        .CNT_W   (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sec_clk (sec_clk),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .sec_left(sec_left)
    );
    assign walk = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic int phase_of(input int pos);
        int durs[7] = '{ALLRED_S, GREEN_S, YELLOW_S, ALLRED_S, GREEN_S, YELLOW_S, WALK_S};
        int bound = 0;
        for (int i = 0; i < 7; i++) begin
            bound += durs[i];
            if (pos < bound) return i;
        end
        return 0;
    endfunction

    function automatic int left_of(input int pos);
        int durs[7] = '{ALLRED_S, GREEN_S, YELLOW_S, ALLRED_S, GREEN_S, YELLOW_S, WALK_S};
        int bound = 0;
        for (int i = 0; i < 7; i++) begin
            bound += durs[i];
            if (pos < bound) return bound - 1 - pos;
        end
        return 0;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [2:0] ns;
        logic [2:0] ew;
        int ph = phase_of(m_pos);
        ns = 3'b100;
        ew = 3'b100;
        if (ph == 1) ns = 3'b001;
        if (ph == 2) ns = 3'b010;
        if (ph == 4) ew = 3'b001;
        if (ph == 5) ew = 3'b010;
        return {ns, ew, CNT_W'(left_of(m_pos)), (ph == 6)};
    endfunction

    function automatic logic [VW-1:0] const_vec(input logic [2:0] ns, input logic [2:0] ew,
                                                input int left, input logic w);
        return {ns, ew, CNT_W'(left), w};
    endfunction

    task automatic model_clock(input logic s, input logic p, input logic r);
        bit pend_old;
        if (!r) begin
            m_pos  = 0;
            m_prev = 1'b0;
            m_pend = 1'b0;
            m_tick = 1'b0;
        end else begin
            pend_old = m_pend;
`ifdef TRAFFIC_PED_EN
            if (p && m_pos < LOOP) m_pend = 1'b1;
`endif
            m_tick = s && !m_prev;
            m_prev = s;
            if (m_tick) begin
                m_pos++;
`ifdef TRAFFIC_PED_EN
                if (m_pos == LOOP) begin
                    if (pend_old) m_pend = 1'b0;
                    else          m_pos = 0;
                end else if (m_pos == LOOP + WALK_S) begin
                    m_pos = 0;
                end
`else
                if (m_pos == LOOP) m_pos = 0;
`endif
            end
        end
    endtask

    task automatic step(input logic s, input logic p, input logic r);
        sec_clk = s;
        ped_req = p;
        rst     = r;
        @(posedge clk);
        model_clock(s, p, r);
        #1;
    endtask

    task automatic sq_step(input logic p);
        sq_n++;
        if (sq_n >= sq_h) begin
            sq   = ~sq;
            sq_n = 0;
        end
        step(sq, p, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0);
        sq   = 1'b0;
        sq_n = 0;
        sq_h = 5;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_total++;
        if ({ns_light, ew_light, sec_left, walk} !== const_vec(3'b100, 3'b100, 0, 1'b0))
            $display("FAIL reset_state got %h want %h", {ns_light, ew_light, sec_left, walk},
                     const_vec(3'b100, 3'b100, 0, 1'b0));
        else n_pass++;
        step(1'b1, 1'b0, 1'b1);
        n_total++;
        if ({ns_light, ew_light, sec_left, walk} !== const_vec(3'b001, 3'b100, 3, 1'b0))
            $display("FAIL release_high_tick got %h want %h", {ns_light, ew_light, sec_left, walk},
                     const_vec(3'b001, 3'b100, 3, 1'b0));
        else n_pass++;
    endtask

    task automatic test_free_run();
        int ticks = 0;
        int cyc = 0;
        int ng = 0, ny = 0, eg = 0, ey = 0, ar = 0;
        int gseq[$];
        int gexp[8] = '{3, 2, 1, 0, 3, 2, 1, 0};
        do_reset();
        while (ticks < LOOP && cyc < 400) begin
            sq_step(1'b0);
            cyc++;
            n_total++;
            if ({ns_light, ew_light, sec_left, walk} !== exp_vec())
                $display("FAIL free_run cyc %0d got %h want %h", cyc,
                         {ns_light, ew_light, sec_left, walk}, exp_vec());
            else n_pass++;
            if (m_tick) begin
                ticks++;
                if (ns_light == 3'b001) ng++;
                if (ns_light == 3'b010) ny++;
                if (ew_light == 3'b001) eg++;
                if (ew_light == 3'b010) ey++;
                if (ns_light == 3'b100 && ew_light == 3'b100) ar++;
                if (ns_light == 3'b001 || ew_light == 3'b001) gseq.push_back(int'(sec_left));
            end
        end
        n_total++;
        if (ticks != LOOP) $display("FAIL free_run_ticks got %0d want %0d", ticks, LOOP);
        else n_pass++;
        n_total++;
        if ({ng, ny, eg, ey, ar} !== {32'd4, 32'd2, 32'd4, 32'd2, 32'd2})
            $display("FAIL phase_lengths got %0d %0d %0d %0d %0d want 4 2 4 2 2", ng, ny, eg, ey, ar);
        else n_pass++;
        n_total++;
        if ({ns_light, ew_light, sec_left} !== {3'b100, 3'b100, CNT_W'(0)})
            $display("FAIL loop_return got %b %b %0d want 100 100 0", ns_light, ew_light, sec_left);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (gseq.size() <= i) $display("FAIL green_count got %0d want 8", gseq.size());
            else if (gseq[i] != gexp[i])
                $display("FAIL green_sec_left idx %0d got %0d want %0d", i, gseq[i], gexp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_tick_edge();
        logic [VW-1:0] prev;
        int changes = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        prev = {ns_light, ew_light, sec_left, walk};
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b0, 1'b1);
            if ({ns_light, ew_light, sec_left, walk} !== prev) changes++;
            prev = {ns_light, ew_light, sec_left, walk};
        end
        n_total++;
        if (changes != 1) $display("FAIL hold_high_advances got %0d want 1", changes);
        else n_pass++;
        n_total++;
        if ({ns_light, ew_light, sec_left, walk} !== exp_vec())
            $display("FAIL hold_high_state got %h want %h", {ns_light, ew_light, sec_left, walk}, exp_vec());
        else n_pass++;
        changes = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if ({ns_light, ew_light, sec_left, walk} !== prev) changes++;
            prev = {ns_light, ew_light, sec_left, walk};
        end
        n_total++;
        if (changes != 0) $display("FAIL falling_edge_changes got %0d want 0", changes);
        else n_pass++;
        sq = 1'b0;
        sq_n = 0;
    endtask

    task automatic test_stall();
        int cyc = 0;
        int changes = 0;
        logic [VW-1:0] prev;
        do_reset();
        while (m_pos != 2 && cyc < 200) begin
            sq_step(1'b0);
            cyc++;
        end
        prev = {ns_light, ew_light, sec_left, walk};
        for (int i = 0; i < 1000; i++) begin
            step(sq, 1'b0, 1'b1);
            if ({ns_light, ew_light, sec_left, walk} !== prev) changes++;
        end
        n_total++;
        if (changes != 0) $display("FAIL stall_changes got %0d want 0", changes);
        else n_pass++;
        n_total++;
        if ({ns_light, ew_light, sec_left, walk} !== const_vec(3'b001, 3'b100, 2, 1'b0))
            $display("FAIL stall_state got %h want %h", {ns_light, ew_light, sec_left, walk},
                     const_vec(3'b001, 3'b100, 2, 1'b0));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        do_reset();
        while (m_pos != 9 && cyc < 300) begin
            sq_step(1'b0);
            cyc++;
        end
        n_total++;
        if ({ns_light, ew_light} !== {3'b100, 3'b001})
            $display("FAIL reach_ew_green got %b %b want 100 001", ns_light, ew_light);
        else n_pass++;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        n_total++;
        if ({ns_light, ew_light, sec_left, walk} !== const_vec(3'b100, 3'b100, 0, 1'b0))
            $display("FAIL reset_mid_state got %h want %h", {ns_light, ew_light, sec_left, walk},
                     const_vec(3'b100, 3'b100, 0, 1'b0));
        else n_pass++;
        step(1'b1, 1'b0, 1'b1);
        n_total++;
        if ({ns_light, ew_light, sec_left, walk} !== const_vec(3'b001, 3'b100, 3, 1'b0))
            $display("FAIL reset_mid_next got %h want %h", {ns_light, ew_light, sec_left, walk},
                     const_vec(3'b001, 3'b100, 3, 1'b0));
        else n_pass++;
    endtask

    task automatic test_safety();
        int ticks = 0;
        int cyc = 0;
        do_reset();
        sq_h = int'($urandom_range(1, 6));
        while (ticks < 3 * LOOP && cyc < 3000) begin
            sq_n++;
            if (sq_n >= sq_h) begin
                sq   = ~sq;
                sq_n = 0;
                sq_h = int'($urandom_range(1, 6));
            end
            step(sq, 1'b0, 1'b1);
            cyc++;
            if (m_tick) ticks++;
            n_total++;
            if (!$onehot(ns_light) || !$onehot(ew_light))
                $display("FAIL onehot cyc %0d got %b %b want one-hot", cyc, ns_light, ew_light);
            else n_pass++;
            n_total++;
            if (!ns_light[2] && !ew_light[2])
                $display("FAIL conflict cyc %0d got %b %b want a red head", cyc, ns_light, ew_light);
            else n_pass++;
            n_total++;
            if ({ns_light, ew_light, sec_left, walk} !== exp_vec())
                $display("FAIL random_model cyc %0d got %h want %h", cyc,
                         {ns_light, ew_light, sec_left, walk}, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (ticks != 3 * LOOP) $display("FAIL safety_ticks got %0d want %0d", ticks, 3 * LOOP);
        else n_pass++;
    endtask

`ifdef TRAFFIC_PED_EN
    task automatic test_ped();
        int cyc = 0;
        int walk_cyc = 0;
        int ticks = 0;
        do_reset();
        while (m_pos != 2 && cyc < 200) begin sq_step(1'b0); cyc++; end
        sq_step(1'b1);
        while (m_pos != LOOP && cyc < 600) begin
            sq_step(1'b0);
            cyc++;
            n_total++;
            if ({ns_light, ew_light, sec_left, walk} !== exp_vec())
                $display("FAIL ped_model cyc %0d got %h want %h", cyc,
                         {ns_light, ew_light, sec_left, walk}, exp_vec());
            else n_pass++;
        end
        n_total++;
        if ({ns_light, ew_light, sec_left, walk} !== const_vec(3'b100, 3'b100, WALK_S - 1, 1'b1))
            $display("FAIL walk_entry got %h want %h", {ns_light, ew_light, sec_left, walk},
                     const_vec(3'b100, 3'b100, WALK_S - 1, 1'b1));
        else n_pass++;
        while (m_pos != LOOP + 1 && cyc < 800) begin sq_step(1'b0); cyc++; end
        sq_step(1'b1);
        while (m_pos != 0 && cyc < 1000) begin
            sq_step(1'b0);
            cyc++;
            if (walk) walk_cyc++;
        end
        n_total++;
        if ({ns_light, ew_light, sec_left, walk} !== const_vec(3'b100, 3'b100, 0, 1'b0))
            $display("FAIL walk_exit got %h want %h", {ns_light, ew_light, sec_left, walk},
                     const_vec(3'b100, 3'b100, 0, 1'b0));
        else n_pass++;
        walk_cyc = 0;
        while (ticks < LOOP && cyc < 2000) begin
            sq_step(1'b0);
            cyc++;
            if (m_tick) ticks++;
            if (walk) walk_cyc++;
        end
        n_total++;
        if (walk_cyc != 0 || ticks != LOOP)
            $display("FAIL second_walk got %0d walk cycles %0d ticks want 0 and %0d", walk_cyc, ticks, LOOP);
        else n_pass++;
        n_total++;
        if ({ns_light, ew_light, walk} !== {3'b100, 3'b100, 1'b0})
            $display("FAIL loop_after_walk got %b %b %b want 100 100 0", ns_light, ew_light, walk);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_tick_edge();
        test_stall();
        test_reset_mid();
        test_safety();
`ifdef TRAFFIC_PED_EN
        test_ped();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Two-way intersection controller that consumes the 1 Hz `clk_out` square wave from `clock_divider` and sequences north-south / east-west signal heads. It edge-detects the seconds input in the `clk` domain and runs a Moore FSM whose every phase lasts a parameterised whole number of seconds. Its outputs drive the board LEDs directly.

## Interface
Parameters:
- `GREEN_S`, default 10: green phase length, seconds (1..2^CNT_W)
- `YELLOW_S`, default 3: yellow phase length, seconds (1..2^CNT_W)
- `ALLRED_S`, default 1: all-red clearance length, seconds (1..2^CNT_W)
- `WALK_S`, default 5: pedestrian walk length, seconds (macro builds only)
- `CNT_W`, default 8: seconds counter width

Ports:
- `clk` in 1: system clock, 100 MHz
- `rst` in 1: synchronous, active-low reset
- `sec_clk` in 1: level from `clock_divider.clk_out`, registered in the `clk` domain
- `ns_light` out 3: {red, yellow, green}, north-south, one-hot
- `ew_light` out 3: {red, yellow, green}, east-west, one-hot
- `sec_left` out CNT_W: seconds remaining in current phase, minus one
- `ped_req` in 1: pedestrian button, synchronous pulse or level (macro builds only)
- `walk` out 1: walk lamp (macro builds only)

## Operation
- Tick detection: `sec_q <= sec_clk` every cycle. `tick = sec_clk & ~sec_q` is one `clk` cycle per second. A falling edge is not a tick.
- States and lamp decode:
  - `ALLRED_A`: NS R, EW R
  - `NS_GREEN`: NS G, EW R
  - `NS_YELLOW`: NS Y, EW R
  - `ALLRED_B`: NS R, EW R
  - `EW_GREEN`: NS R, EW G
  - `EW_YELLOW`: NS R, EW Y
  - `WALK`: NS R, EW R, `walk`=1 (macro only)
- Lamps are a pure decode of the state register. Exactly one lamp per head is lit at all times.
- Transition order: ALLRED_A → NS_GREEN → NS_YELLOW → ALLRED_B → EW_GREEN → EW_YELLOW → ALLRED_A.
- Counter behaviour:
  - On entry to a state, `cnt` loads (duration − 1).
  - On a tick with `cnt` ≠ 0, `cnt` decrements.
  - On a tick with `cnt` = 0, the FSM advances and `cnt` loads the next state's duration − 1.
  - Each phase therefore lasts exactly its duration in ticks.
- No tick, no change. State and count hold indefinitely if `sec_clk` stops.
- `sec_left` = `cnt`.
- Illegal state encoding → ALLRED_A with `cnt` = ALLRED_S − 1 on the next clock (both heads red).

## Timing
- Reset (`rst`=0 at a `clk` edge) sets:
  - state = ALLRED_A, `cnt` = ALLRED_S − 1, `sec_q` = 0
  - `ns_light` = `ew_light` = 3'b100, `walk` = 0, pending = 0
- Reset has priority over any tick in the same cycle.
- Reset mid-phase abandons the phase. After release, the first tick is evaluated against the ALLRED_A count.
- `sec_clk` sampled high with `sec_q` low at edge k: state and `cnt` update at edge k, and lamps change in the same cycle. Latency from the `sec_clk` register edge to lamp change is 1 `clk` cycle.
- If `sec_clk` is already 1 when `rst` releases, the first edge after release counts as a tick, because `sec_q` was reset to 0.
- Minimum legal `sec_clk` high and low time is 1 `clk` cycle each. Every rising edge yields exactly one tick.

## Configuration
- Macro: `TRAFFIC_PED_EN`.
- Defined:
  - `ped_req`, `walk` and `WALK_S` exist.
  - `ped_req`=1 on any cycle outside WALK sets a pending flag.
  - When EW_YELLOW expires and pending=1, the FSM enters WALK (`cnt` = WALK_S − 1) instead of ALLRED_A.
  - When WALK expires, the FSM goes to ALLRED_A.
  - Pending is cleared on the edge that enters WALK. Requests seen while in WALK are dropped.
- Undefined: ports, parameter and WALK state are absent. The sequence is the fixed six-state loop.

## Test plan
Use GREEN_S=4, YELLOW_S=2, ALLRED_S=1, WALK_S=3 for all scenarios, and drive `sec_clk` as a register toggled every 5 `clk` cycles.
- Reset then free-run:
  - Lamps are 100/100 after reset.
  - NS_GREEN lasts exactly 4 ticks, NS_YELLOW 2, ALLRED_B 1, EW_GREEN 4, EW_YELLOW 2.
  - The loop returns to ALLRED_A after 14 ticks total.
  - `sec_left` counts 3,2,1,0 during each green.
- Tick edge only: hold `sec_clk`=1 for 50 cycles → exactly one advance. A falling edge causes no change.
- Stall: stop `sec_clk` mid-NS_GREEN with `sec_left`=2 → state and `sec_left` are unchanged after 1000 cycles.
- Reset mid-EW_GREEN: assert `rst`=0 for 1 cycle coincident with a tick → lamps 100/100, `sec_left`=0, and the next tick enters NS_GREEN.
- Safety invariants, checked every cycle across 3 full loops:
  - Never green or yellow on both heads at once.
  - Each of `ns_light` and `ew_light` is always one-hot.
- Pedestrian (`TRAFFIC_PED_EN`):
  - Pulse `ped_req` during NS_GREEN → after EW_YELLOW the FSM enters WALK with `walk`=1 and both heads red for 3 ticks, then goes to ALLRED_A.
  - A request pulsed during WALK does not cause a second WALK.
